// File: rtl/imem_prog_loader.sv
// Boot-time program loader: parses a length/payload/checksum byte frame, writes
// little-endian 32-bit words into IMEM and releases the core once the checksum verifies.
module imem_prog_loader #(
   parameter int IMEM_AW    = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   input  logic                  restart,
   output logic                  imem_we,
   output logic [IMEM_AW-1:0]    imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  core_rst_n,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {LEN0, LEN1, DATA, CHECK, RUN, ERR} state_t;

   localparam logic [16:0] CAP = 17'(1) << IMEM_AW;

   state_t                  state_q, state_d;
   logic [15:0]             len_q, len_d;
   logic [IMEM_AW:0]        word_idx_q, word_idx_d;
   logic [1:0]              byte_idx_q, byte_idx_d;
   logic [7:0]              acc_q, acc_d;
   logic [23:0]             asm_q, asm_d;
   logic                    in_ready_q, in_ready_d;
   logic                    imem_we_q, imem_we_d;
   logic [IMEM_AW-1:0]      imem_addr_q, imem_addr_d;
   logic [DATA_WIDTH-1:0]   imem_wdata_q, imem_wdata_d;
   logic                    core_rst_n_q, core_rst_n_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;

   logic        xfer;
   logic [16:0] n_full;
   logic        last_word;

   assign xfer      = in_valid && in_ready_q;
   assign n_full    = {1'b0, in_data, len_q[7:0]};
   assign last_word = (17'(word_idx_q) + 17'd1) == {1'b0, len_q};

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      word_idx_d   = word_idx_q;
      byte_idx_d   = byte_idx_q;
      acc_d        = acc_q;
      asm_d        = asm_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      case (state_q)
         LEN0: if (xfer) begin
            len_d[7:0] = in_data;
            acc_d      = acc_q ^ in_data;
            state_d    = LEN1;
         end
         LEN1: if (xfer) begin
            len_d[15:8] = in_data;
            acc_d       = acc_q ^ in_data;
            word_idx_d  = '0;
            byte_idx_d  = '0;
            if (n_full > CAP)        state_d = ERR;
            else if (n_full == 17'd0) state_d = CHECK;
            else                      state_d = DATA;
         end
         DATA: if (xfer) begin
            acc_d      = acc_q ^ in_data;
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
               2'd0: asm_d[7:0]   = in_data;
               2'd1: asm_d[15:8]  = in_data;
               2'd2: asm_d[23:16] = in_data;
               default: begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = word_idx_q[IMEM_AW-1:0];
                  imem_wdata_d = {in_data, asm_q};
                  word_idx_d   = word_idx_q + 1'b1;
                  if (last_word) state_d = CHECK;
               end
            endcase
         end
         CHECK: if (xfer) state_d = (in_data == acc_q) ? RUN : ERR;
         RUN, ERR: if (restart) begin
            state_d    = LEN0;
            acc_d      = '0;
            word_idx_d = '0;
            byte_idx_d = '0;
         end
         default: state_d = LEN0;
      endcase
      // Status outputs are registered images of the next state.
      in_ready_d   = (state_d == LEN0) || (state_d == LEN1) ||
                     (state_d == DATA) || (state_d == CHECK);
      core_rst_n_d = (state_d == RUN);
      done_d       = (state_d == RUN);
      error_d      = (state_d == ERR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= LEN0;
         len_q        <= '0;
         word_idx_q   <= '0;
         byte_idx_q   <= '0;
         acc_q        <= '0;
         asm_q        <= '0;
         in_ready_q   <= 1'b1;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         core_rst_n_q <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_idx_q   <= word_idx_d;
         byte_idx_q   <= byte_idx_d;
         acc_q        <= acc_d;
         asm_q        <= asm_d;
         in_ready_q   <= in_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         core_rst_n_q <= core_rst_n_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign core_rst_n = core_rst_n_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Bench for imem_prog_loader (IMEM_AW=4): table frames, hand corner sequences and
// random frames, all checked against a frame-level reference model.
module tb_imem_prog_loader;

   localparam int AW  = 4;
   localparam int CAP = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          restart;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_rst_n;
   logic          done;
   logic          error;

   imem_prog_loader #(.IMEM_AW(AW), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .restart(restart), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_rst_n(core_rst_n), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   logic [63:0] obs_q[$];
   logic [63:0] exp_q[$];
   bit          exp_done, exp_err;

   always @(negedge clk) if (imem_we) obs_q.push_back({32'(imem_addr), imem_wdata});

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: interpret the frame from its definition (count, words, xor checksum).
   task automatic model(input logic [7:0] fb[$]);
      int n;
      logic [7:0] x;
      exp_q.delete();
      n = int'(fb[0]) | (int'(fb[1]) << 8);
      if (n > CAP) begin
         exp_done = 0; exp_err = 1;
      end else begin
         x = 8'h00;
         for (int i = 0; i < fb.size() - 1; i++) x ^= fb[i];
         for (int w = 0; w < n; w++)
            exp_q.push_back({32'(w), fb[2+4*w+3], fb[2+4*w+2], fb[2+4*w+1], fb[2+4*w]});
         exp_done = (fb[fb.size()-1] == x);
         exp_err  = !exp_done;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output bit ok);
      ok = 0;
      in_valid = 1'b1;
      in_data  = b;
      for (int t = 0; t < 20 && !ok; t++) begin
         if (in_ready) ok = 1;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] fb[$], input int gapmax);
      int n, g, w;
      bit ok;
      n = int'(fb[0]) | (int'(fb[1]) << 8);
      for (int i = 0; i < fb.size(); i++) begin
         g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
         repeat (g) @(negedge clk);
         send_byte(fb[i], ok);
         if (!ok) begin
            chk("byte_accept_timeout", 64'(i), 64'hFFFF);
            break;
         end
         // Write strobe must appear on the cycle right after a word's 4th byte.
         if (n <= CAP && i >= 2 && i < 2 + 4*n && ((i - 2) % 4) == 3) begin
            w = (i - 2) / 4;
            chk("we_latency", 64'(imem_we), 64'd1);
            chk("we_addr", 64'(imem_addr), 64'(w));
            chk("we_data", 64'(imem_wdata), {32'd0, fb[i], fb[i-1], fb[i-2], fb[i-3]});
         end
      end
   endtask

   task automatic final_check(input logic [7:0] fb[$]);
      model(fb);
      chk("write_count", 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         chk("write_entry", obs_q[i], exp_q[i]);
      chk("done", 64'(done), 64'(exp_done));
      chk("error", 64'(error), 64'(exp_err));
      chk("core_rst_n", 64'(core_rst_n), 64'(exp_done));
      chk("in_ready_final", 64'(in_ready), 64'd0);
   endtask

   task automatic do_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("rs_in_ready", 64'(in_ready), 64'd1);
      chk("rs_done", 64'(done), 64'd0);
      chk("rs_error", 64'(error), 64'd0);
      chk("rs_core_rst_n", 64'(core_rst_n), 64'd0);
      obs_q.delete();
   endtask

   typedef struct {
      logic [7:0] b[0:11];
      int         nb;
      int         gap;
      bit         exp_done;
      bit         exp_err;
   } vec_t;

   vec_t       tbl[6];
   logic [7:0] fb[$];

   initial begin
      bit ok;
      int n, sz;
      logic [7:0] x;

      tbl[0] = '{'{8'h02,8'h00,8'h13,8'h00,8'hA0,8'h00,8'h93,8'h00,8'h50,8'h00,8'h72,8'h00}, 11, 0, 1, 0};
      tbl[1] = '{'{8'h02,8'h00,8'h13,8'h00,8'hA0,8'h00,8'h93,8'h00,8'h50,8'h00,8'h73,8'h00}, 11, 0, 0, 1};
      tbl[2] = '{'{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 0, 1, 0};
      tbl[3] = '{'{8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 0, 0, 1};
      tbl[4] = '{'{8'h02,8'h00,8'h13,8'h00,8'hA0,8'h00,8'h93,8'h00,8'h50,8'h00,8'h72,8'h00}, 11, 3, 1, 0};
      tbl[5] = '{'{8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,8'h23,8'h00,8'h00,8'h00,8'h00,8'h00}, 7, 2, 1, 0};

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; restart = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_imem_we", 64'(imem_we), 64'd0);
      chk("rst_addr", 64'(imem_addr), 64'd0);
      chk("rst_wdata", 64'(imem_wdata), 64'd0);
      chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         fb.delete();
         for (int i = 0; i < tbl[v].nb; i++) fb.push_back(tbl[v].b[i]);
         send_frame(fb, tbl[v].gap);
         final_check(fb);
         chk("tbl_done", 64'(done), 64'(tbl[v].exp_done));
         chk("tbl_error", 64'(error), 64'(tbl[v].exp_err));
         // Bytes offered while not ready must be ignored.
         sz = obs_q.size();
         in_valid = 1'b1; in_data = 8'h5A;
         repeat (3) @(negedge clk);
         in_valid = 1'b0;
         chk("idle_no_write", 64'(obs_q.size()), 64'(sz));
         chk("idle_done_hold", 64'(done), 64'(tbl[v].exp_done));
         do_restart();
      end

      // Reset in the middle of DATA, right as the first write strobe is up.
      fb = '{8'h02,8'h00,8'h13,8'h00,8'hA0,8'h00,8'h93,8'h00,8'h50,8'h00,8'h72};
      for (int i = 0; i < 6; i++) send_byte(fb[i], ok);
      rst = 1'b1;
      #1;
      chk("mid_rst_we", 64'(imem_we), 64'd0);
      chk("mid_rst_addr", 64'(imem_addr), 64'd0);
      chk("mid_rst_wdata", 64'(imem_wdata), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_core_rst_n", 64'(core_rst_n), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      obs_q.delete();
      @(negedge clk);
      send_frame(fb, 0);
      final_check(fb);
      do_restart();

      // Restart while mid-frame is ignored.
      send_byte(fb[0], ok);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      for (int i = 1; i < fb.size(); i++) send_byte(fb[i], ok);
      final_check(fb);
      do_restart();

      // Full-capacity frame: last write lands at CAP-1.
      fb.delete();
      fb.push_back(8'(CAP)); fb.push_back(8'h00);
      for (int i = 0; i < 4*CAP; i++) fb.push_back(8'($urandom));
      x = 8'h00;
      foreach (fb[i]) x ^= fb[i];
      fb.push_back(x);
      send_frame(fb, 1);
      final_check(fb);
      do_restart();

      // Random frames: sizes 0..CAP+2, random gaps, half with corrupted checksum.
      for (int r = 0; r < 40; r++) begin
         fb.delete();
         n = int'($urandom_range(CAP + 2, 0));
         fb.push_back(8'(n)); fb.push_back(8'(n >> 8));
         if (n <= CAP) begin
            for (int i = 0; i < 4*n; i++) fb.push_back(8'($urandom));
            x = 8'h00;
            foreach (fb[i]) x ^= fb[i];
            if ($urandom_range(1, 0) == 1) x ^= 8'h01 << $urandom_range(7, 0);
            fb.push_back(x);
         end
         send_frame(fb, 3);
         final_check(fb);
         do_restart();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
